// File: rtl/ysyx_clint_pkg.sv
// Shared constants, read-state enum and byte-strobe helper for the CLINT.
// Optional prescaler is enabled with YSYX_CLINT_PRESCALE_EN.
package ysyx_clint_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [3:0] OFF_LO = 4'd0;
    localparam logic [3:0] OFF_HI = 4'd4;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } r_state_e;

    function automatic logic [31:0] strb_merge(
        input logic [31:0] old,
        input logic [31:0] wdata,
        input logic [3:0]  wstrb
    );
        logic [31:0] res;
        res = old;
        for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) begin
                res[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ysyx_clint_mtime.sv
// 64-bit mtime counter with byte-strobed word writes.
// YSYX_CLINT_PRESCALE_EN adds a divider so mtime advances every PRESCALE cycles.
module ysyx_clint_mtime
    import ysyx_clint_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wen,
    input  logic        whi,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic [63:0] mtime
);

    logic [63:0] wr_val;
    logic        tick;

    always_comb begin
        wr_val = mtime;
        if (whi) begin
            wr_val[63:32] = strb_merge(mtime[63:32], wdata, wstrb);
        end else begin
            wr_val[31:0] = strb_merge(mtime[31:0], wdata, wstrb);
        end
    end

`ifdef YSYX_CLINT_PRESCALE_EN
    localparam int DIV_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(PRESCALE - 1);

    logic [DIV_W-1:0] div;

    assign tick = (div == DIV_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div <= '0;
        end else if (wen || tick) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end
`else
    localparam int unused_prescale = PRESCALE;

    assign tick = 1'b1;
`endif

    // A write in the same cycle as a tick wins; that tick is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime <= '0;
        end else if (wen) begin
            mtime <= wr_val;
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

endmodule

// File: rtl/ysyx_clint.sv
// CLINT mtime behind a single-beat AXI4 slave: read FSM, write latches, decode.
// Optional prescaler is enabled with YSYX_CLINT_PRESCALE_EN.
module ysyx_clint
    import ysyx_clint_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RTC_ADDR = 32'h0200_BFF8,
    parameter int                PRESCALE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        arburst,
    input  logic [2:0]        arsize,
    input  logic [7:0]        arlen,
    input  logic [3:0]        arid,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic              arready_o,
    output logic [3:0]        rid,
    output logic              rlast_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [1:0]        rresp_o,
    output logic              rvalid_o,
    input  logic              rready,
    input  logic [1:0]        awburst,
    input  logic [2:0]        awsize,
    input  logic [7:0]        awlen,
    input  logic [3:0]        awid,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready_o,
    input  logic              wlast,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        wstrb,
    input  logic              wvalid,
    output logic              wready_o,
    output logic [3:0]        bid,
    output logic [1:0]        bresp_o,
    output logic              bvalid_o,
    input  logic              bready
);

    localparam logic [ADDR_W-1:0] ADDR_LO = RTC_ADDR + ADDR_W'(OFF_LO);
    localparam logic [ADDR_W-1:0] ADDR_HI = RTC_ADDR + ADDR_W'(OFF_HI);

    logic [63:0] mtime;

    logic unused_ok;
    assign unused_ok = ^{arburst, arsize, arlen, awburst, awsize, awlen, wlast};

    r_state_e          r_state;
    logic              ar_lo;
    logic              ar_hi;
    logic [DATA_W-1:0] rd_word;

    assign ar_lo     = (araddr == ADDR_LO);
    assign ar_hi     = (araddr == ADDR_HI);
    assign arready_o = (r_state == R_IDLE);
    assign rlast_o   = rvalid_o;

    always_comb begin
        rd_word = '0;
        unique case (1'b1)
            ar_lo:   rd_word = mtime[31:0];
            ar_hi:   rd_word = mtime[63:32];
            default: rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= R_IDLE;
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
            rid      <= '0;
            rresp_o  <= RESP_OKAY;
        end else begin
            unique case (r_state)
                R_IDLE: begin
                    if (arvalid) begin
                        r_state  <= R_RESP;
                        rvalid_o <= 1'b1;
                        rdata_o  <= rd_word;
                        rid      <= arid;
                        rresp_o  <= (ar_lo || ar_hi) ? RESP_OKAY : RESP_SLVERR;
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        r_state  <= R_IDLE;
                        rvalid_o <= 1'b0;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    logic              aw_full;
    logic [ADDR_W-1:0] aw_addr;
    logic [3:0]        aw_id;
    logic              w_full;
    logic [31:0]       w_data;
    logic [3:0]        w_strb;
    logic              wr_go;
    logic              wr_lo;
    logic              wr_hi;

    assign awready_o = !aw_full;
    assign wready_o  = !w_full;
    assign wr_go     = aw_full && w_full && !bvalid_o;
    assign wr_lo     = (aw_addr == ADDR_LO);
    assign wr_hi     = (aw_addr == ADDR_HI);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aw_full <= 1'b0;
            aw_addr <= '0;
            aw_id   <= '0;
        end else if (wr_go) begin
            aw_full <= 1'b0;
        end else if (!aw_full && awvalid) begin
            aw_full <= 1'b1;
            aw_addr <= awaddr;
            aw_id   <= awid;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_full <= 1'b0;
            w_data <= '0;
            w_strb <= '0;
        end else if (wr_go) begin
            w_full <= 1'b0;
        end else if (!w_full && wvalid) begin
            w_full <= 1'b1;
            w_data <= wdata;
            w_strb <= wstrb;
        end
    end

    // Latches may refill while a response waits; they apply after bready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bvalid_o <= 1'b0;
            bid      <= '0;
            bresp_o  <= RESP_OKAY;
        end else if (wr_go) begin
            bvalid_o <= 1'b1;
            bid      <= aw_id;
            bresp_o  <= (wr_lo || wr_hi) ? RESP_OKAY : RESP_SLVERR;
        end else if (bvalid_o && bready) begin
            bvalid_o <= 1'b0;
        end
    end

    ysyx_clint_mtime #(
        .PRESCALE (PRESCALE)
    ) u_mtime (
        .clk   (clk),
        .rst   (rst),
        .wen   (wr_go && (wr_lo || wr_hi)),
        .whi   (wr_hi),
        .wstrb (w_strb),
        .wdata (w_data),
        .mtime (mtime)
    );

endmodule

// File: tb/tb_ysyx_clint.sv
// Bench for ysyx_clint: transaction-level model checked every cycle plus literals.
// Build with YSYX_CLINT_PRESCALE_EN to exercise the divider path.
module tb_ysyx_clint;

    localparam int          PRESCALE = 4;
    localparam logic [31:0] RTC      = 32'h0200_BFF8;

    logic        clk;
    logic        rst;
    logic [1:0]  arburst;
    logic [2:0]  arsize;
    logic [7:0]  arlen;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready_o;
    logic [3:0]  rid;
    logic        rlast_o;
    logic [31:0] rdata_o;
    logic [1:0]  rresp_o;
    logic        rvalid_o;
    logic        rready;
    logic [1:0]  awburst;
    logic [2:0]  awsize;
    logic [7:0]  awlen;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready_o;
    logic        wlast;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready_o;
    logic [3:0]  bid;
    logic [1:0]  bresp_o;
    logic        bvalid_o;
    logic        bready;

    ysyx_clint #(
        .PRESCALE (PRESCALE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .arburst   (arburst),
        .arsize    (arsize),
        .arlen     (arlen),
        .arid      (arid),
        .araddr    (araddr),
        .arvalid   (arvalid),
        .arready_o (arready_o),
        .rid       (rid),
        .rlast_o   (rlast_o),
        .rdata_o   (rdata_o),
        .rresp_o   (rresp_o),
        .rvalid_o  (rvalid_o),
        .rready    (rready),
        .awburst   (awburst),
        .awsize    (awsize),
        .awlen     (awlen),
        .awid      (awid),
        .awaddr    (awaddr),
        .awvalid   (awvalid),
        .awready_o (awready_o),
        .wlast     (wlast),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wvalid    (wvalid),
        .wready_o  (wready_o),
        .bid       (bid),
        .bresp_o   (bresp_o),
        .bvalid_o  (bvalid_o),
        .bready    (bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    longint unsigned m_time;
    int              m_div;
    bit              r_pend;
    logic [31:0]     r_data;
    logic [1:0]      r_resp;
    logic [3:0]      r_id;
    bit              aw_has;
    logic [31:0]     aw_a;
    logic [3:0]      aw_i;
    bit              w_has;
    logic [31:0]     w_d;
    logic [3:0]      w_s;
    bit              b_pend;
    logic [1:0]      b_resp;
    logic [3:0]      b_id;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_time = 0;
        m_div  = 0;
        r_pend = 0;
        aw_has = 0;
        w_has  = 0;
        b_pend = 0;
    endtask

    // One clock edge of the CLINT as a transaction-level machine.
    task automatic model_update();
        bit              do_wr, r_acc, r_rel, b_rel, aw_take, w_take;
        bit              hit_lo, hit_hi;
        longint unsigned nt;
        logic [31:0]     word;
        if (!rst) begin
            model_clear();
            return;
        end
        do_wr   = aw_has && w_has && !b_pend;
        b_rel   = b_pend && bready;
        r_acc   = !r_pend && arvalid;
        r_rel   = r_pend && rready;
        aw_take = !aw_has && awvalid;
        w_take  = !w_has && wvalid;
`ifdef YSYX_CLINT_PRESCALE_EN
        if (m_div == PRESCALE - 1) begin
            m_div = 0;
            nt = m_time + 1;
        end else begin
            m_div++;
            nt = m_time;
        end
`else
        nt = m_time + 1;
`endif
        if (do_wr) begin
            hit_lo = (aw_a == RTC);
            hit_hi = (aw_a == RTC + 4);
            if (hit_lo || hit_hi) begin
                word = hit_hi ? m_time[63:32] : m_time[31:0];
                for (int i = 0; i < 4; i++)
                    if (w_s[i]) word[8*i +: 8] = w_d[8*i +: 8];
                nt = hit_hi ? {word, m_time[31:0]} : {m_time[63:32], word};
                m_div = 0;
            end
            b_pend = 1;
            b_resp = (hit_lo || hit_hi) ? 2'b00 : 2'b10;
            b_id   = aw_i;
            aw_has = 0;
            w_has  = 0;
        end else if (b_rel) begin
            b_pend = 0;
        end
        if (r_acc) begin
            r_pend = 1;
            r_id   = arid;
            if (araddr == RTC) begin
                r_data = m_time[31:0];
                r_resp = 2'b00;
            end else if (araddr == RTC + 4) begin
                r_data = m_time[63:32];
                r_resp = 2'b00;
            end else begin
                r_data = 0;
                r_resp = 2'b10;
            end
        end else if (r_rel) begin
            r_pend = 0;
        end
        if (aw_take) begin
            aw_has = 1;
            aw_a   = awaddr;
            aw_i   = awid;
        end
        if (w_take) begin
            w_has = 1;
            w_d   = wdata;
            w_s   = wstrb;
        end
        m_time = nt;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("arready", 64'(arready_o), 64'(!r_pend));
            check("rvalid", 64'(rvalid_o), 64'(r_pend));
            check("rlast", 64'(rlast_o), 64'(r_pend));
            check("awready", 64'(awready_o), 64'(!aw_has));
            check("wready", 64'(wready_o), 64'(!w_has));
            check("bvalid", 64'(bvalid_o), 64'(b_pend));
            if (r_pend) begin
                check("rdata", 64'(rdata_o), 64'(r_data));
                check("rresp", 64'(rresp_o), 64'(r_resp));
                check("rid", 64'(rid), 64'(r_id));
            end
            if (b_pend) begin
                check("bresp", 64'(bresp_o), 64'(b_resp));
                check("bid", 64'(bid), 64'(b_id));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic rd(input logic [31:0] a, input logic [3:0] id,
                      output logic [31:0] d);
        arvalid = 1'b1;
        araddr  = a;
        arid    = id;
        step();
        arvalid = 1'b0;
        check("rd_rvalid_lat1", 64'(rvalid_o), 64'd1);
        d = rdata_o;
        step();
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] id,
                      input logic [31:0] d, input logic [3:0] s);
        awvalid = 1'b1;
        awaddr  = a;
        awid    = id;
        wvalid  = 1'b1;
        wdata   = d;
        wstrb   = s;
        step();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        step();
        check("wr_bvalid_lat", 64'(bvalid_o), 64'd1);
        check("wr_bid", 64'(bid), 64'(id));
        step();
    endtask

    logic [31:0] d, d0, d1;

    initial begin
        rst = 1'b1;
        {arburst, arsize, arlen, arid, araddr, arvalid} = '0;
        {awburst, awsize, awlen, awid, awaddr, awvalid} = '0;
        {wlast, wdata, wstrb, wvalid} = '0;
        rready = 1'b1;
        bready = 1'b1;
        model_clear();
        #1 rst = 1'b0;
        #1 chk_en = 1'b1;
        check("rst_rvalid", 64'(rvalid_o), 64'd0);
        check("rst_bvalid", 64'(bvalid_o), 64'd0);
        check("rst_rdata", 64'(rdata_o), 64'd0);
        check("rst_rid_bid", 64'({rid, bid}), 64'd0);
        check("rst_resp", 64'({rresp_o, bresp_o}), 64'd0);
        check("rst_readies", 64'({arready_o, awready_o, wready_o}), 64'b111);
        idle(2);
        rst = 1'b1;

        idle(10);
        rd(RTC, 4'h3, d);
`ifdef YSYX_CLINT_PRESCALE_EN
        check("t1_rdata", 64'(d), 64'd2);
`else
        check("t1_rdata", 64'(d), 64'd10);
`endif

        wr(RTC + 4, 4'h1, 32'h0, 4'hF);
        wr(RTC, 4'h2, 32'hFFFF_FFFF, 4'hF);
        idle(3);
`ifdef YSYX_CLINT_PRESCALE_EN
        idle(8);
`endif
        rd(RTC + 4, 4'h4, d);
        check("t2_carry_hi", 64'(d), 64'd1);
        rd(RTC, 4'h4, d);

        rready  = 1'b0;
        arvalid = 1'b1;
        araddr  = RTC;
        arid    = 4'h9;
        step();
        arvalid = 1'b0;
        d0 = rdata_o;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t3_hold_data", 64'(rdata_o), 64'(d0));
            check("t3_hold_rid", 64'(rid), 64'h9);
            check("t3_arready_lo", 64'(arready_o), 64'd0);
        end
        rready  = 1'b1;
        arvalid = 1'b1;
        araddr  = RTC + 4;
        arid    = 4'h6;
        step();
        check("t3_release_ar", 64'(arready_o), 64'd1);
        step();
        arvalid = 1'b0;
        check("t3_next_rid", 64'(rid), 64'h6);
        step();

        bready = 1'b0;
        wvalid = 1'b1;
        wdata  = 32'h0000_AB00;
        wstrb  = 4'b0010;
        step();
        wvalid = 1'b0;
        idle(3);
        awvalid = 1'b1;
        awaddr  = RTC;
        awid    = 4'hA;
        step();
        awvalid = 1'b0;
        check("t4_b_not_yet", 64'(bvalid_o), 64'd0);
        step();
        check("t4_bvalid", 64'(bvalid_o), 64'd1);
        check("t4_bid", 64'(bid), 64'hA);
        awvalid = 1'b1;
        awaddr  = RTC + 4;
        awid    = 4'hB;
        wvalid  = 1'b1;
        wdata   = 32'h0000_0005;
        wstrb   = 4'b0001;
        step();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        step();
        check("t4_b_held_bid", 64'(bid), 64'hA);
        bready = 1'b1;
        idle(3);
        rd(RTC, 4'h1, d);
        check("t4_byte1", 64'(d[15:8]), 64'hAB);
        rd(RTC + 4, 4'h1, d);
        check("t4_hi_byte0", 64'(d), 64'h5);

        rd(RTC + 8, 4'h2, d);
        check("t5_err_rdata", 64'(d), 64'd0);
        step();
        arvalid = 1'b1;
        araddr  = RTC + 8;
        step();
        arvalid = 1'b0;
        check("t5_rresp", 64'(rresp_o), 64'h2);
        step();
        awvalid = 1'b1;
        awaddr  = RTC + 8;
        awid    = 4'h7;
        wvalid  = 1'b1;
        wdata   = 32'h0;
        wstrb   = 4'hF;
        step();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        step();
        check("t5_bresp", 64'(bresp_o), 64'h2);
        step();
        rd(RTC + 4, 4'h2, d);
        check("t5_hi_kept", 64'(d), 64'h5);

        rd(RTC, 4'h3, d0);
        idle(38);
        rd(RTC, 4'h3, d1);
`ifdef YSYX_CLINT_PRESCALE_EN
        check("t6_advance", 64'(d1 - d0), 64'd10);
`else
        check("t6_advance", 64'(d1 - d0), 64'd40);
`endif

        rready  = 1'b0;
        bready  = 1'b0;
        arvalid = 1'b1;
        araddr  = RTC;
        awvalid = 1'b1;
        awaddr  = RTC + 8;
        wvalid  = 1'b1;
        step();
        {arvalid, awvalid, wvalid} = '0;
        step();
        check("t6_pre_rvalid", 64'(rvalid_o), 64'd1);
        check("t6_pre_bvalid", 64'(bvalid_o), 64'd1);
        rst = 1'b0;
        model_clear();
        #1;
        check("t6_rst_rvalid", 64'(rvalid_o), 64'd0);
        check("t6_rst_bvalid", 64'(bvalid_o), 64'd0);
        check("t6_rst_arready", 64'(arready_o), 64'd1);
        step();
        rst    = 1'b1;
        rready = 1'b1;
        bready = 1'b1;
        idle(3);
        rd(RTC, 4'h0, d);
`ifdef YSYX_CLINT_PRESCALE_EN
        check("t6_post_rst", 64'(d), 64'd0);
`else
        check("t6_post_rst", 64'(d), 64'd3);
`endif
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
